// File: rtl/mat_pkg.sv
// Shared constants, state encoding and index helpers for the matrix result reader.
// MAT_RD_TRANSPOSE_EN selects column-major streaming order in next_pos().
package mat_pkg;

  localparam int unsigned MAT_DIM    = 5;
  localparam int unsigned MAT_ELEM_W = 8;
  localparam int unsigned MAT_W      = MAT_DIM * MAT_DIM * MAT_ELEM_W;
  localparam int unsigned MAT_IDX_W  = 3;

  localparam logic [MAT_IDX_W-1:0] MAT_LAST_IDX = MAT_IDX_W'(MAT_DIM - 1);

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } mat_state_e;

  typedef struct packed {
    logic [MAT_IDX_W-1:0] row;
    logic [MAT_IDX_W-1:0] col;
  } mat_pos_t;

  // Bit offset of element (row,col) inside the flat result word.
  function automatic int unsigned elem_off(input int unsigned row, input int unsigned col);
    return MAT_DIM * MAT_ELEM_W * row + MAT_ELEM_W * col;
  endfunction

  // Next stream position; wraps the minor index and bumps the major one.
  function automatic mat_pos_t next_pos(input mat_pos_t p);
    mat_pos_t n;
    n = p;
`ifdef MAT_RD_TRANSPOSE_EN
    if (p.row == MAT_LAST_IDX) begin
      n.row = '0;
      n.col = p.col + MAT_IDX_W'(1);
    end else begin
      n.row = p.row + MAT_IDX_W'(1);
    end
`else
    if (p.col == MAT_LAST_IDX) begin
      n.col = '0;
      n.row = p.row + MAT_IDX_W'(1);
    end else begin
      n.col = p.col + MAT_IDX_W'(1);
    end
`endif
    return n;
  endfunction

endpackage

// File: rtl/mat_result_reader_if.sv
// Element stream from the result reader to the HPS-facing sink.
interface mat_result_reader_if;
  import mat_pkg::*;

  logic [MAT_ELEM_W-1:0] out_data;
  logic [MAT_IDX_W-1:0]  out_row;
  logic [MAT_IDX_W-1:0]  out_col;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  out_ovf;

  modport master (
    output out_data, out_row, out_col, out_valid, out_last, out_ovf,
    input  out_ready
  );

  modport slave (
    input  out_data, out_row, out_col, out_valid, out_last, out_ovf,
    output out_ready
  );

endinterface

// File: rtl/mat_elem_sel.sv
// Combinational pick of one element from the flat matrix word by row/column.
module mat_elem_sel
  import mat_pkg::*;
(
  input  logic [MAT_W-1:0]      mat,
  input  logic [MAT_IDX_W-1:0]  row,
  input  logic [MAT_IDX_W-1:0]  col,
  output logic [MAT_ELEM_W-1:0] elem
);

  // Out-of-range indices fall through to zero.
  always_comb begin
    elem = '0;
    for (int unsigned i = 0; i < MAT_DIM; i++) begin
      for (int unsigned j = 0; j < MAT_DIM; j++) begin
        if (row == MAT_IDX_W'(i) && col == MAT_IDX_W'(j)) begin
          elem = mat[elem_off(i, j) +: MAT_ELEM_W];
        end
      end
    end
  end

endmodule

// File: rtl/mat_result_reader.sv
// Snapshots the multiplier result on done rising and drains it as a 25-beat stream.
// Define MAT_RD_TRANSPOSE_EN for column-major beat order.
module mat_result_reader
  import mat_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MAT_W-1:0]     mat_in,
  input  logic                 ovf_in,
  input  logic                 done_in,
  output logic                 busy,
  output logic                 drop_pulse,
  mat_result_reader_if.master  stream
);

  mat_state_e        state;
  logic              done_q;
  logic [MAT_W-1:0]  shadow;
  mat_pos_t          pos;
  logic              ovf_q;
  logic              drop_q;

  logic done_rise;
  logic accept;
  logic at_last;

  assign done_rise = done_in & ~done_q;
  assign accept    = (state == ST_STREAM) & stream.out_ready;
  assign at_last   = (pos.row == MAT_LAST_IDX) && (pos.col == MAT_LAST_IDX);

  // Capture/stream FSM; a rise coinciding with the final accept restarts without a gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
      shadow <= '0;
      pos    <= '0;
      ovf_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      done_q <= done_in;
      drop_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (done_rise) begin
            shadow <= mat_in;
            ovf_q  <= ovf_in;
            pos    <= '0;
            state  <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (done_rise && !(accept && at_last)) begin
            drop_q <= 1'b1;
          end
          if (accept) begin
            if (at_last) begin
              pos <= '0;
              if (done_rise) begin
                shadow <= mat_in;
                ovf_q  <= ovf_in;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              pos <= next_pos(pos);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mat_elem_sel u_sel (
    .mat  (shadow),
    .row  (pos.row),
    .col  (pos.col),
    .elem (stream.out_data)
  );

  assign stream.out_valid = (state == ST_STREAM);
  assign stream.out_row   = pos.row;
  assign stream.out_col   = pos.col;
  assign stream.out_last  = (state == ST_STREAM) & at_last;
  assign stream.out_ovf   = ovf_q;
  assign busy             = (state == ST_STREAM);
  assign drop_pulse       = drop_q;

endmodule

// File: doc/mat_result_reader.md
# mat_result_reader

Consumes the flat 200-bit result of the 5x5 signed 8-bit matrix multiplier and delivers it to the HPS-facing side as a 25-beat element stream with valid/ready flow control. Detects the multiplier's `done` rising edge, snapshots result and overflow into a shadow register, then streams elements with row/column tags and a last marker. This frees the multiplier to start the next operation while the previous result drains.

## Interface

- `DIM`, 5: matrix dimension; rows and columns.
- `ELEM_W`, 8: element width, two's complement.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mat_in` in DIM*DIM*ELEM_W (200): multiplier result.
  - Element (i,j) is at bits [40i+8j+7 : 40i+8j].
- `ovf_in` in 1: multiplier overflow; valid while `done_in` is high.
- `done_in` in 1: multiplier completion level.
- `out_data` out ELEM_W: current element.
- `out_row` out 3: row index of `out_data`.
- `out_col` out 3: column index of `out_data`.
- `out_valid` out 1: beat valid.
- `out_ready` in 1: sink accepts the beat.
- `out_last` out 1: high on the 25th beat.
- `out_ovf` out 1: snapshot overflow flag, constant during a stream.
- `busy` out 1: stream in progress.
- `drop_pulse` out 1: one-cycle pulse when a result was lost because `busy` was high.

## Operation

- States: IDLE, STREAM.
- Edge detect:
  - `done_q` register, reset 0.
  - `done_rise = done_in & ~done_q`.
- IDLE:
  - On `done_rise`: load `shadow <= mat_in` and `out_ovf <= ovf_in`, reset index to 0, go to STREAM.
  - Otherwise hold.
- STREAM:
  - `out_valid = 1`.
  - A beat is accepted when `out_valid & out_ready`.
  - On acceptance, advance the index: row-major, col 0..4 then row+1.
  - Acceptance at index 24 returns the block to IDLE.
- Output values:
  - `out_data` is the element at (`out_row`, `out_col`) of `shadow`.
  - `out_last = (index == 24)`.
- Back-pressure: while `out_ready = 0`, `out_data`, `out_row`, `out_col` and `out_last` hold stable.
- `done_rise` while in STREAM, except on the final-accept cycle:
  - The result is ignored.
  - `drop_pulse` goes high for 1 cycle.
  - The shadow register is untouched.
- `done_rise` on the same edge as the final accept:
  - The new result is captured.
  - The block stays in STREAM and restarts at index 0.
  - `out_valid` stays high; no gap cycle, no drop.
- `done_in` held high produces no further captures; it must fall and rise again.
- Reset asserted mid-stream aborts the stream immediately; no partial completion.
- Reset values:
  - `out_valid`, `out_last`, `out_ovf`, `busy` and `drop_pulse` are 0.
  - Index, `out_row`, `out_col` and `out_data` are 0.
  - `shadow` is 0; state is IDLE; `done_q` is 0.

## Timing

- Capture latency: `done_in` sampled high with `done_q = 0` at edge t; `out_valid = 1` and element (0,0) are presented from edge t.
- Stream length: minimum 25 cycles with `out_ready` tied high.
- Back-to-back: a new stream begins on the edge after the final accept of the previous one.
- `busy` equals `out_valid`.
- All outputs are registered or decoded from registers only; there is no combinational path from `out_ready` or `done_in` to any output.

## Configuration

- `MAT_RD_TRANSPOSE_EN` defined:
  - Index advances column-major: row 0..4, then col+1.
  - The stream delivers the transpose order.
  - `out_row` and `out_col` still report the element's true position.
  - `out_last` is asserted on (4,4) as before.
- Undefined: row-major order as described above.

## Structure

- Package `mat_pkg` holds:
  - `MAT_DIM = 5`, `MAT_ELEM_W = 8`, `MAT_W = 200`.
  - The state encoding (`ST_IDLE`, `ST_STREAM`).
  - A function or constant for the element bit offset, 40i+8j.
- Sub-module `mat_elem_sel`: purely combinational select of one ELEM_W element from the 200-bit shadow, indexed by row and column.
- Top level holds the FSM, row/col counters, edge detect and output registers.

## Test plan

- Basic stream:
  - Stimulus: `mat_in` element (i,j) = 5i+j; `done_in` 0→1; `out_ready = 1`.
  - Response: 25 beats with data 0..24 in order; `out_last` only on data 24 at (4,4); `out_valid` falls after it.
- Overflow:
  - Stimulus: `ovf_in = 1` at capture; `ovf_in` then driven to 0 during the stream.
  - Response: `out_ovf = 1` for all 25 beats.
- Back-pressure:
  - Stimulus: `out_ready` toggles 1,0,0,1 repeatedly.
  - Response: data stays stable while not ready; no beat is lost or duplicated; 25 accepts total.
- Drop:
  - Stimulus: a second `done_in` rise at beat 10, with `mat_in` changed to all 0x7F.
  - Response: `drop_pulse` high for 1 cycle; beats 10..24 still carry the original data.
- Coincident capture:
  - Stimulus: `done_in` rises on the final-accept edge, with new `mat_in` all 0x80.
  - Response: the next cycle shows `out_valid = 1`, data 0x80 at (0,0); `drop_pulse` stays 0.
- Reset and transpose:
  - Stimulus: `rst_n` low at beat 12.
  - Response: all outputs 0 and the block idle.
  - Stimulus: with `MAT_RD_TRANSPOSE_EN` defined, repeat basic stream.
  - Response: data order 0,5,10,15,20,1,6,…,24.
